// File: rtl/rx_frame_sanitizer_if.sv
// Avalon-ST beat bundle. There is no ready signal because the source cannot be stalled.
interface avln_st;
  logic [31:0] data;
  logic        sop;
  logic        eop;
  logic [1:0]  empty;
  logic        valid;

  modport master (output data, sop, eop, empty, valid);
  modport slave  (input  data, sop, eop, empty, valid);
endinterface

// File: rtl/rx_frame_sanitizer.sv
// rx_frame_sanitizer: repairs a raw Avalon-ST receive stream so that every
// packet starts with sop, ends with exactly one eop and holds at most
// MAX_BEATS beats. The most recent beat of an open packet is held back in a
// one-entry register H. This lets a missing eop be forced onto it when a new
// sop arrives, when the packet runs too long, or when the source goes quiet.
module rx_frame_sanitizer #(
  parameter int MAX_BEATS = 384,
  parameter int TIMEOUT   = 64
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  avln_st.slave       in,
  avln_st.master      out,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] MAX_CNT   = BW'(MAX_BEATS);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_DISCARD} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;    // in H this also marks the beat as final
    logic [1:0]  empty;
  } beat_t;

  state_t        state, state_nx;
  beat_t         hold, hold_nx, in_beat, emit_beat;
  logic          hold_vld, hold_vld_nx;
  logic [BW-1:0] beat_cnt, beat_cnt_nx, load_cnt;
  logic [IW-1:0] idle_cnt, idle_cnt_nx;
  logic          emit, load;
  logic [1:0]    err_inc;
  logic [16:0]   err_sum;

  assign in_beat = {in.data, in.sop, in.eop, in.empty};
  assign err_sum = {1'b0, err_count} + 17'(err_inc);

  // State register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next state, what leaves H this edge, what gets loaded into H, and error count.
  always_comb begin
    state_nx    = state;
    hold_nx     = hold;
    hold_vld_nx = hold_vld;
    beat_cnt_nx = beat_cnt;
    idle_cnt_nx = idle_cnt;
    emit        = 1'b0;
    emit_beat   = hold;
    err_inc     = 2'd0;
    load        = 1'b0;
    load_cnt    = beat_cnt;

    // A final beat always leaves on the edge after it was loaded. This
    // happens whatever the input does on that edge.
    if (hold_vld && hold.eop) begin
      emit        = 1'b1;
      hold_vld_nx = 1'b0;
    end

    case (state)
      S_IDLE, S_DISCARD: begin
        if (in.valid) begin
          if (in.sop) begin
            load     = 1'b1;
            load_cnt = BW'(1);
          end else if (state == S_IDLE) begin
            err_inc = 2'd1;                 // orphan beat, dropped
          end else if (in.eop) begin
            state_nx = S_IDLE;              // end of the truncated tail
          end
        end
      end
      S_OPEN: begin
        if (in.valid) begin
          emit = 1'b1;
          load = 1'b1;
          if (in.sop) begin
            // The previous packet never closed, so close it here.
            emit_beat.eop   = 1'b1;
            emit_beat.empty = 2'd0;
            err_inc         = 2'd1;
            load_cnt        = BW'(1);
          end else begin
            load_cnt = beat_cnt + BW'(1);
          end
        end else if (idle_cnt == IDLE_LAST) begin
          emit          = 1'b1;
          emit_beat.eop = 1'b1;
          err_inc       = 2'd1;
          hold_vld_nx   = 1'b0;
          idle_cnt_nx   = '0;
          state_nx      = S_IDLE;
        end else begin
          idle_cnt_nx = idle_cnt + IW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Any sop beat is handled the same way here, whichever state it arrives in.
    if (load) begin
      hold_nx     = in_beat;
      hold_vld_nx = 1'b1;
      beat_cnt_nx = load_cnt;
      idle_cnt_nx = '0;
      if (in.eop) begin
        state_nx = S_IDLE;
      end else if (load_cnt == MAX_CNT) begin
        hold_nx.eop   = 1'b1;
        hold_nx.empty = 2'd0;
        err_inc       = err_inc + 2'd1;
        state_nx      = S_DISCARD;
      end else begin
        state_nx = S_OPEN;
      end
    end
  end

  // Hold register, counters and the registered output beat.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold      <= '0;
      hold_vld  <= 1'b0;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
      out.data  <= '0;
      out.sop   <= 1'b0;
      out.eop   <= 1'b0;
      out.empty <= '0;
      out.valid <= 1'b0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      hold      <= hold_nx;
      hold_vld  <= hold_vld_nx;
      beat_cnt  <= beat_cnt_nx;
      idle_cnt  <= idle_cnt_nx;
      out.valid <= emit;
      if (emit) begin
        out.data  <= emit_beat.data;
        out.sop   <= emit_beat.sop;
        out.eop   <= emit_beat.eop;
        out.empty <= emit_beat.empty;
      end
      if (emit && emit_beat.eop && pkt_count != 16'hFFFF)
        pkt_count <= pkt_count + 16'd1;
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule
